// File: rtl/sum_serial_tx.sv
// Serial transmitter for 8-bit result bytes.
// A frame is one start bit (0), eight data bits LSB first, an optional even
// parity bit and one stop bit (1). Each bit lasts CLKS_PER_BIT clock cycles.
// A byte is accepted with a valid/ready handshake while the line is idle.
module sum_serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Terminal count of the per-bit cycle counter.
    localparam logic [7:0] CNT_MAX = 8'(CLKS_PER_BIT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shreg_q, shreg_d;
    logic       par_q, par_d;
    logic       tx_q, tx_d;
    logic       rdy_q, rdy_d;
    logic       bit_done;

    // Last cycle of the current bit period.
    always_comb begin
        bit_done = (cnt_q == CNT_MAX);
    end

    // Next-state, counter and shift-register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                idx_d = 3'd0;
                // in_ready is 1 whenever the state is IDLE, so in_valid alone
                // completes the handshake here.
                if (in_valid) begin
                    state_d = START;
                    shreg_d = in_data;
                    par_d   = ^in_data;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    cnt_d   = 8'd0;
                    idx_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d   = 8'd0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
                idx_d   = 3'd0;
            end
        endcase
    end

    // Line level and ready flag for the next cycle, derived from the next state
    // so both come straight out of flops.
    always_comb begin
        tx_d  = 1'b1;
        rdy_d = (state_d == IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            shreg_q <= 8'd0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            rdy_q   <= rdy_d;
        end
    end

    assign tx       = tx_q;
    assign in_ready = rdy_q;
    assign busy     = ~rdy_q;

endmodule
